// File: rtl/conv_layer_sequencer.sv
// Row-pass sequencer for a convolution layer: walks channels, rows and kernels,
// issuing one-cycle PRELOAD/SHIFT/LOAD commands to the input interface.
module conv_layer_sequencer #(
    parameter int unsigned NUM_KERNELS  = 4,
    parameter int unsigned NUM_ROWS     = 6,
    parameter int unsigned NUM_CHANNELS = 1,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           input_interface_ack,
    output logic [1:0]           input_interface_cmd,
    output logic [CNT_WIDTH-1:0] kernel_idx,
    output logic [CNT_WIDTH-1:0] row_idx,
    output logic [CNT_WIDTH-1:0] channel_idx,
    output logic [2:0]           current_state,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPreload = 3'd1,
        StShift   = 3'd2,
        StLoad    = 3'd3,
        StDone    = 3'd4
    } state_e;

    localparam logic [1:0] CmdIdle    = 2'd0;
    localparam logic [1:0] CmdPreload = 2'd1;
    localparam logic [1:0] CmdShift   = 2'd2;
    localparam logic [1:0] CmdLoad    = 2'd3;

    localparam logic [1:0] AckPreloadFin = 2'd1;
    localparam logic [1:0] AckShiftFin   = 2'd2;
    localparam logic [1:0] AckLoadFin    = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CntOne      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] KernelLast  = CNT_WIDTH'(NUM_KERNELS - 1);
    localparam logic [CNT_WIDTH-1:0] RowLast     = CNT_WIDTH'(NUM_ROWS - 1);
    localparam logic [CNT_WIDTH-1:0] ChannelLast = CNT_WIDTH'(NUM_CHANNELS - 1);

    state_e               state_q, state_d;
    logic [1:0]           cmd_q, cmd_d;
    logic [CNT_WIDTH-1:0] kernel_q, kernel_d;
    logic [CNT_WIDTH-1:0] row_q, row_d;
    logic [CNT_WIDTH-1:0] channel_q, channel_d;

    always_comb begin
        state_d   = state_q;
        cmd_d     = CmdIdle;
        kernel_d  = kernel_q;
        row_d     = row_q;
        channel_d = channel_q;

        if (enable) begin
            if (abort) begin
                state_d   = StIdle;
                kernel_d  = '0;
                row_d     = '0;
                channel_d = '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            state_d   = StPreload;
                            cmd_d     = CmdPreload;
                            kernel_d  = '0;
                            row_d     = '0;
                            channel_d = '0;
                        end
                    end
                    StPreload: begin
                        if (input_interface_ack == AckPreloadFin) begin
                            state_d = StShift;
                            cmd_d   = CmdShift;
                        end
                    end
                    StShift: begin
                        if (input_interface_ack == AckShiftFin) begin
                            if (kernel_q < KernelLast) begin
                                kernel_d = kernel_q + CntOne;
                                cmd_d    = CmdShift;
                            end else if (row_q < RowLast) begin
                                kernel_d = '0;
                                state_d  = StLoad;
                                cmd_d    = CmdLoad;
                            end else if (channel_q < ChannelLast) begin
                                kernel_d  = '0;
                                row_d     = '0;
                                channel_d = channel_q + CntOne;
                                state_d   = StPreload;
                                cmd_d     = CmdPreload;
                            end else begin
                                // Last pass of the layer: indices hold through DONE.
                                state_d = StDone;
                            end
                        end
                    end
                    StLoad: begin
                        if (input_interface_ack == AckLoadFin) begin
                            row_d   = row_q + CntOne;
                            state_d = StShift;
                            cmd_d   = CmdShift;
                        end
                    end
                    StDone: begin
                        state_d   = StIdle;
                        kernel_d  = '0;
                        row_d     = '0;
                        channel_d = '0;
                    end
                    default: begin
                        state_d   = StIdle;
                        kernel_d  = '0;
                        row_d     = '0;
                        channel_d = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cmd_q     <= CmdIdle;
            kernel_q  <= '0;
            row_q     <= '0;
            channel_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            kernel_q  <= kernel_d;
            row_q     <= row_d;
            channel_q <= channel_d;
        end
    end

    assign input_interface_cmd = cmd_q;
    assign kernel_idx          = kernel_q;
    assign row_idx             = row_q;
    assign channel_idx         = channel_q;
    assign current_state       = state_q;
    assign busy                = (state_q != StIdle);
    // DONE lasts one enabled cycle, so done is a single pulse per layer.
    assign done                = (state_q == StDone);

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: a 4x2x2 instance for the full layer,
// ack filtering, enable freeze, abort and reset, plus a 1x1x1 instance.
module tb_conv_layer_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_en = 1'b1, a_start = 1'b0, a_abort = 1'b0;
    logic [1:0] a_ack = 2'd0, a_cmd;
    logic [7:0] a_kernel, a_row, a_chan;
    logic [2:0] a_state;
    logic       a_busy, a_done;

    logic       b_en = 1'b1, b_start = 1'b0, b_abort = 1'b0;
    logic [1:0] b_ack = 2'd0, b_cmd;
    logic [7:0] b_kernel, b_row, b_chan;
    logic [2:0] b_state;
    logic       b_busy, b_done;

    conv_layer_sequencer #(
        .NUM_KERNELS (4),
        .NUM_ROWS    (2),
        .NUM_CHANNELS(2),
        .CNT_WIDTH   (8)
    ) u_dut_a (
        .clk                (clk),
        .rst                (rst),
        .enable             (a_en),
        .start              (a_start),
        .abort              (a_abort),
        .input_interface_ack(a_ack),
        .input_interface_cmd(a_cmd),
        .kernel_idx         (a_kernel),
        .row_idx            (a_row),
        .channel_idx        (a_chan),
        .current_state      (a_state),
        .busy               (a_busy),
        .done               (a_done)
    );

    conv_layer_sequencer #(
        .NUM_KERNELS (1),
        .NUM_ROWS    (1),
        .NUM_CHANNELS(1),
        .CNT_WIDTH   (8)
    ) u_dut_b (
        .clk                (clk),
        .rst                (rst),
        .enable             (b_en),
        .start              (b_start),
        .abort              (b_abort),
        .input_interface_ack(b_ack),
        .input_interface_cmd(b_cmd),
        .kernel_idx         (b_kernel),
        .row_idx            (b_row),
        .channel_idx        (b_chan),
        .current_state      (b_state),
        .busy               (b_busy),
        .done               (b_done)
    );

    int errors = 0;
    int checks = 0;

    logic [1:0] a_q[$];
    logic [1:0] b_q[$];
    logic [1:0] a_last_cmd;
    int a_np, a_ns, a_nl, a_ndone;
    int b_nl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and score any command pulse against the expected queue.
    task automatic a_tick();
        logic [1:0] exp;
        @(posedge clk);
        #1;
        a_last_cmd = a_cmd;
        if (a_cmd !== 2'd0) begin
            if (a_q.size() == 0) begin
                chk("a_cmd_unexpected", 32'(a_cmd), 32'd0);
            end else begin
                exp = a_q.pop_front();
                chk("a_cmd_seq", 32'(a_cmd), 32'(exp));
            end
            if (a_cmd == 2'd1) a_np++;
            if (a_cmd == 2'd2) a_ns++;
            if (a_cmd == 2'd3) a_nl++;
        end
        if (a_done === 1'b1) a_ndone++;
    endtask

    task automatic b_tick();
        logic [1:0] exp;
        @(posedge clk);
        #1;
        if (b_cmd !== 2'd0) begin
            if (b_q.size() == 0) begin
                chk("b_cmd_unexpected", 32'(b_cmd), 32'd0);
            end else begin
                exp = b_q.pop_front();
                chk("b_cmd_seq", 32'(b_cmd), 32'(exp));
            end
            if (b_cmd == 2'd3) b_nl++;
        end
    endtask

    initial begin
        logic [1:0] pend;
        int cnt;
        bit seen_done;

        // Reset state
        #12;
        chk("rst_state", 32'(a_state), 32'd0);
        chk("rst_cmd", 32'(a_cmd), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_idx", 32'({a_kernel, a_row, a_chan}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full layer with acks 3 cycles after each command
        a_np = 0; a_ns = 0; a_nl = 0; a_ndone = 0;
        for (int ch = 0; ch < 2; ch++) begin
            a_q.push_back(2'd1);
            for (int r = 0; r < 2; r++) begin
                for (int k = 0; k < 4; k++) a_q.push_back(2'd2);
                if (r < 1) a_q.push_back(2'd3);
            end
        end
        a_start = 1'b1;
        a_tick();
        a_start = 1'b0;
        pend = a_last_cmd;
        cnt = 2;
        seen_done = 1'b0;
        for (int i = 0; i < 400 && !seen_done; i++) begin
            a_tick();
            a_ack = 2'd0;
            if (a_last_cmd != 2'd0) begin
                pend = a_last_cmd;
                cnt = 2;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) a_ack = pend;
            end
            if (a_done === 1'b1) seen_done = 1'b1;
        end
        a_ack = 2'd0;
        chk("full_done_seen", 32'(seen_done), 32'd1);
        chk("full_done_state", 32'(a_state), 32'd4);
        chk("full_done_kernel", 32'(a_kernel), 32'd3);
        a_tick();
        chk("full_after_done", 32'(a_done), 32'd0);
        chk("full_after_state", 32'(a_state), 32'd0);
        chk("full_after_idx", 32'({a_kernel, a_row, a_chan}), 32'd0);
        a_tick();
        chk("full_preload_cnt", 32'(a_np), 32'd2);
        chk("full_shift_cnt", 32'(a_ns), 32'd16);
        chk("full_load_cnt", 32'(a_nl), 32'd2);
        chk("full_done_cnt", 32'(a_ndone), 32'd1);
        chk("full_queue_empty", 32'(a_q.size()), 32'd0);

        // Mismatched ack in SHIFT with kernel_idx=1
        a_q.push_back(2'd1);
        a_start = 1'b1;
        a_tick();
        a_start = 1'b0;
        a_q.push_back(2'd2);
        a_ack = 2'd1;
        a_tick();
        a_q.push_back(2'd2);
        a_ack = 2'd2;
        a_tick();
        chk("mis_kernel_before", 32'(a_kernel), 32'd1);
        a_ack = 2'd3;
        a_tick();
        a_ack = 2'd0;
        chk("mis_state", 32'(a_state), 32'd2);
        chk("mis_kernel", 32'(a_kernel), 32'd1);
        chk("mis_cmd", 32'(a_cmd), 32'd0);

        // Enable low in LOAD: acks in the window are lost
        repeat (2) begin
            a_q.push_back(2'd2);
            a_ack = 2'd2;
            a_tick();
        end
        a_q.push_back(2'd3);
        a_ack = 2'd2;
        a_tick();
        a_ack = 2'd0;
        chk("en_in_load", 32'(a_state), 32'd3);
        chk("en_kernel_clr", 32'(a_kernel), 32'd0);
        a_en = 1'b0;
        a_ack = 2'd3;
        repeat (5) begin
            a_tick();
            chk("en_frozen", 32'(a_state), 32'd3);
        end
        a_en = 1'b1;
        a_ack = 2'd0;
        a_tick();
        chk("en_ack_lost", 32'(a_state), 32'd3);
        chk("en_row_hold", 32'(a_row), 32'd0);
        a_q.push_back(2'd2);
        a_ack = 2'd3;
        a_tick();
        a_ack = 2'd0;
        chk("en_resume_state", 32'(a_state), 32'd2);
        chk("en_resume_row", 32'(a_row), 32'd1);

        // Abort in SHIFT with channel_idx=1 and simultaneous SHIFT_FIN
        repeat (3) begin
            a_q.push_back(2'd2);
            a_ack = 2'd2;
            a_tick();
        end
        a_q.push_back(2'd1);
        a_ack = 2'd2;
        a_tick();
        chk("ch1_state", 32'(a_state), 32'd1);
        chk("ch1_chan", 32'(a_chan), 32'd1);
        chk("ch1_row", 32'(a_row), 32'd0);
        a_q.push_back(2'd2);
        a_ack = 2'd1;
        a_tick();
        chk("ch1_shift", 32'(a_state), 32'd2);
        a_abort = 1'b1;
        a_ack = 2'd2;
        a_tick();
        a_abort = 1'b0;
        a_ack = 2'd0;
        chk("abort_state", 32'(a_state), 32'd0);
        chk("abort_idx", 32'({a_kernel, a_row, a_chan}), 32'd0);
        chk("abort_done", 32'(a_done), 32'd0);
        chk("abort_cmd", 32'(a_cmd), 32'd0);
        chk("abort_busy", 32'(a_busy), 32'd0);

        // Reset asserted in LOAD
        a_q.push_back(2'd1);
        a_start = 1'b1;
        a_tick();
        a_start = 1'b0;
        a_q.push_back(2'd2);
        a_ack = 2'd1;
        a_tick();
        repeat (3) begin
            a_q.push_back(2'd2);
            a_ack = 2'd2;
            a_tick();
        end
        a_q.push_back(2'd3);
        a_ack = 2'd2;
        a_tick();
        a_ack = 2'd0;
        chk("rst_pre_load", 32'(a_state), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_state", 32'(a_state), 32'd0);
        chk("rst_mid_cmd", 32'(a_cmd), 32'd0);
        chk("rst_mid_busy", 32'(a_busy), 32'd0);
        chk("rst_mid_done", 32'(a_done), 32'd0);
        chk("rst_mid_idx", 32'({a_kernel, a_row, a_chan}), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        a_tick();
        chk("rst_wait_idle", 32'(a_state), 32'd0);
        a_q.push_back(2'd1);
        a_start = 1'b1;
        a_tick();
        a_start = 1'b0;
        chk("rst_restart_cmd", 32'(a_last_cmd), 32'd1);
        chk("rst_restart_state", 32'(a_state), 32'd1);
        a_abort = 1'b1;
        a_tick();
        a_abort = 1'b0;
        chk("a_queue_final", 32'(a_q.size()), 32'd0);

        // Degenerate 1x1x1 layer: no LOAD at all
        b_nl = 0;
        b_q.push_back(2'd1);
        b_q.push_back(2'd2);
        b_start = 1'b1;
        b_tick();
        b_start = 1'b0;
        chk("b_preload", 32'(b_state), 32'd1);
        b_ack = 2'd1;
        b_tick();
        chk("b_shift", 32'(b_state), 32'd2);
        b_ack = 2'd2;
        b_tick();
        b_ack = 2'd0;
        chk("b_done_state", 32'(b_state), 32'd4);
        chk("b_done_pulse", 32'(b_done), 32'd1);
        chk("b_done_cmd", 32'(b_cmd), 32'd0);
        b_tick();
        chk("b_after_done", 32'(b_done), 32'd0);
        chk("b_after_state", 32'(b_state), 32'd0);
        chk("b_no_load", 32'(b_nl), 32'd0);
        chk("b_queue_final", 32'(b_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
